ram_bist_ctrl: RTL and testbench

// Built-in self-test initiator for the single-port synchronous-write /

---
 rtl/ram_bist_ctrl_if.sv | 25 ++
 rtl/ram_bist_ctrl.sv | 158 +++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ram_bist_ctrl_if.sv
// RAM port bundle between the BIST initiator (master) and the RAM (slave).
// Write side is registered in the master; read data returns combinationally.
interface ram_bist_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_bist_ctrl.sv
// RAM BIST initiator: two fill-and-verify passes (pattern, then inverted), pass/fail report.
// Optional first-failure capture (err_addr/err_data) when RAM_BIST_ERR_LOG_EN is defined.
module ram_bist_ctrl #(
  parameter int              ADDR_W  = 4,
  parameter int              DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(8'h5A)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  ram_bist_ctrl_if.master     ram,
  output logic                busy,
  output logic                done,
  output logic                pass
`ifdef RAM_BIST_ERR_LOG_EN
  ,
  output logic [ADDR_W-1:0]   err_addr,
  output logic [DATA_W-1:0]   err_data
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    WR1  = 3'd3,
    RD1  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              fail_q;
`ifdef RAM_BIST_ERR_LOG_EN
  logic [ADDR_W-1:0] err_addr_q;
  logic [DATA_W-1:0] err_data_q;
`endif

  logic [ADDR_W-1:0] addr_d;
  logic              last_addr;
  logic              inv_pass;
  logic [DATA_W-1:0] rd_exp;
  logic              mismatch;

  // Pass 0 writes PATTERN ^ addr, pass 1 writes its complement.
  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a,
                                                 input logic               inv);
    logic [DATA_W-1:0] v;
    v = PATTERN ^ DATA_W'(a);
    return inv ? ~v : v;
  endfunction

  assign addr_d    = addr_q + ADDR_W'(1);
  assign last_addr = (addr_q == {ADDR_W{1'b1}});
  assign inv_pass  = (state_q == WR1) || (state_q == RD1);
  assign rd_exp    = exp_data(addr_q, inv_pass);
  assign mismatch  = (ram.ram_rdata != rd_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
`ifdef RAM_BIST_ERR_LOG_EN
      err_addr_q <= '0;
      err_data_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= WR0;
            we_q       <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= exp_data('0, 1'b0);
            busy_q     <= 1'b1;
            fail_q     <= 1'b0;
            pass_q     <= 1'b0;
`ifdef RAM_BIST_ERR_LOG_EN
            err_addr_q <= '0;
            err_data_q <= '0;
`endif
          end
        end
        WR0, WR1: begin
          if (last_addr) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            state_q <= (state_q == WR0) ? RD0 : RD1;
          end else begin
            addr_q  <= addr_d;
            wdata_q <= exp_data(addr_d, inv_pass);
          end
        end
        RD0, RD1: begin
          // Read data is compared in the cycle its address is presented.
          if (mismatch) begin
            fail_q <= 1'b1;
`ifdef RAM_BIST_ERR_LOG_EN
            if (!fail_q) begin
              err_addr_q <= addr_q;
              err_data_q <= ram.ram_rdata;
            end
`endif
          end
          if (last_addr) begin
            addr_q <= '0;
            if (state_q == RD0) begin
              state_q <= WR1;
              we_q    <= 1'b1;
              wdata_q <= exp_data('0, 1'b1);
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= ~(fail_q | mismatch);
            end
          end else begin
            addr_q <= addr_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ram.ram_we    = we_q;
  assign ram.ram_addr  = addr_q;
  assign ram.ram_wdata = wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
`ifdef RAM_BIST_ERR_LOG_EN
  assign err_addr      = err_addr_q;
  assign err_data      = err_data_q;
`endif

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl: RAM model with optional stuck-at fault,
// write/result scoreboard queues filled at start and drained as the DUT responds.
module tb_ram_bist_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fault_en;
  logic [7:0] mem [16];
`ifdef RAM_BIST_ERR_LOG_EN
  logic [3:0] err_addr;
  logic [7:0] err_data;
`endif

  int checks;
  int errors;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t wq[$];
  bit  pq[$];

  ram_bist_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  ram_bist_ctrl #(.ADDR_W(4), .DATA_W(8), .PATTERN(8'h5A)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ram      (bus),
    .busy     (busy),
    .done     (done),
    .pass     (pass)
`ifdef RAM_BIST_ERR_LOG_EN
    ,
    .err_addr (err_addr),
    .err_data (err_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: synchronous write, asynchronous read; fault forces bit 0 of word 6 high.
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_wdata;
  end
  assign bus.ram_rdata = mem[bus.ram_addr] |
                         ((fault_en && bus.ram_addr == 4'd6) ? 8'h01 : 8'h00);

  function automatic logic [7:0] expd(input int a, input int p);
    logic [7:0] v;
    v = 8'h5A ^ 8'(a);
    return (p != 0) ? ~v : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic run_test(input bit do_pulse, input bit keep_high, input bit exp_pass,
                          input int p1, input int p2, input int abort_k,
                          input logic [3:0] exp_ea, input logic [7:0] exp_ed);
    wr_t w;
    bit  ep;
    if (do_pulse) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 16; a++) begin
        w.a = 4'(a);
        w.d = expd(a, p);
        wq.push_back(w);
      end
    end
    pq.push_back(exp_pass);
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      if (!keep_high) start = (k == p1) || (k == p2);
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        chk("abort_we",   32'(bus.ram_we),   0);
        chk("abort_busy", 32'(busy),         0);
        chk("abort_addr", 32'(bus.ram_addr), 0);
        chk("abort_pass", 32'(pass),         0);
        repeat (2) begin
          @(negedge clk);
          chk("abort_done", 32'(done), 0);
          chk("abort_busy_hold", 32'(busy), 0);
        end
        rst_n = 1'b1;
        wq.delete();
        pq.delete();
        return;
      end
      chk("busy", 32'(busy), 32'(k <= 64));
      chk("done", 32'(done), 32'(k == 65));
      chk("we", 32'(bus.ram_we), 32'((k <= 16) || (k >= 33 && k <= 48)));
      chk("addr", 32'(bus.ram_addr), (k <= 64) ? 32'((k - 1) % 16) : 32'd0);
      if (bus.ram_we === 1'b1) begin
        if (wq.size() == 0) begin
          chk("wq_underflow", 32'(wq.size()), 1);
        end else begin
          w = wq.pop_front();
          chk("wr_addr",  32'(bus.ram_addr),  32'(w.a));
          chk("wr_wdata", 32'(bus.ram_wdata), 32'(w.d));
        end
      end
      if (k == 65) begin
        if (pq.size() == 0) begin
          chk("pq_underflow", 32'(pq.size()), 1);
        end else begin
          ep = pq.pop_front();
          chk("pass_at_done", 32'(pass), 32'(ep));
        end
`ifdef RAM_BIST_ERR_LOG_EN
        chk("err_addr", 32'(err_addr), 32'(exp_ea));
        chk("err_data", 32'(err_data), 32'(exp_ed));
`endif
      end else if (k < 65) begin
        chk("pass_cleared", 32'(pass), 0);
      end else begin
        chk("pass_hold", 32'(pass), 32'(exp_pass));
      end
    end
    chk("wq_left", 32'(wq.size()), 0);
    chk("pq_left", 32'(pq.size()), 0);
    if (exp_ea == 4'hF && exp_ed == 8'hFF) chk("unused_err_args", 0, 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    fault_en = 1'b0;
    #12;
    chk("rst_busy",  32'(busy),          0);
    chk("rst_done",  32'(done),          0);
    chk("rst_pass",  32'(pass),          0);
    chk("rst_we",    32'(bus.ram_we),    0);
    chk("rst_addr",  32'(bus.ram_addr),  0);
    chk("rst_wdata", 32'(bus.ram_wdata), 0);
`ifdef RAM_BIST_ERR_LOG_EN
    chk("rst_err_addr", 32'(err_addr), 0);
    chk("rst_err_data", 32'(err_data), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Good RAM: full run, write sequence, final contents.
    run_test(1'b1, 1'b0, 1'b1, 0, 0, 0, 4'h0, 8'h00);
    chk("mem3", 32'(mem[3]), 32'h0000_00A6);
    chk("wdata_hold", 32'(bus.ram_wdata), 32'h0000_00AA);

    // Stuck-at-1 on bit 0 of word 6: first miss at addr 6 reading 5D.
    fault_en = 1'b1;
    run_test(1'b1, 1'b0, 1'b0, 0, 0, 0, 4'h6, 8'h5D);
    fault_en = 1'b0;

    // Start pulses during a test are ignored.
    run_test(1'b1, 1'b0, 1'b1, 10, 40, 0, 4'h0, 8'h00);

    // Reset mid RD0, then a clean full run.
    run_test(1'b1, 1'b0, 1'b1, 0, 0, 30, 4'h0, 8'h00);
    run_test(1'b1, 1'b0, 1'b1, 0, 0, 0, 4'h0, 8'h00);

    // Start held high: second test begins from IDLE straight after DONE.
    run_test(1'b1, 1'b1, 1'b1, 0, 0, 0, 4'h0, 8'h00);
    run_test(1'b0, 1'b0, 1'b1, 0, 0, 0, 4'h0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
